// File: rtl/opfetch_pkg.sv
// Shared defaults and bundle types for the operand fetch controller.
// Optional writeback bypass is enabled by defining OPFETCH_FORWARD_EN.
package opfetch_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_DEPTH_LOG = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_DEPTH_LOG-1:0] src_a;
    logic [DEF_DEPTH_LOG-1:0] src_b;
    logic [DEF_DEPTH_LOG-1:0] dst;
    logic                     wr_en;
  } instr_t;

  typedef struct packed {
    logic                     valid;
    logic [DEF_DEPTH_LOG-1:0] dst;
    logic [DEF_WIDTH-1:0]     data;
  } wb_t;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Per-register busy tracking with set/clear ports (set wins on the same index)
// and the busy lookups the issue logic needs for hazard detection.
module opfetch_scoreboard
  import opfetch_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 set_en,
  input  logic [DEPTH_LOG-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [DEPTH_LOG-1:0] clr_idx,
  input  logic [DEPTH_LOG-1:0] src_a,
  input  logic [DEPTH_LOG-1:0] src_b,
  input  logic [DEPTH_LOG-1:0] dst,
  output logic [DEPTH-1:0]     busy,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic                 busy_dst
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      // The set term is checked first so an issue targeting the register being
      // written back in the same cycle keeps it busy.
      assign busy_next[gi] = (set_en && set_idx == DEPTH_LOG'(gi)) ? 1'b1 :
                             (clr_en && clr_idx == DEPTH_LOG'(gi)) ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign busy     = busy_reg;
  assign busy_a   = busy_reg[src_a];
  assign busy_b   = busy_reg[src_b];
  assign busy_dst = busy_reg[dst];

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Decode-to-execute operand fetch: register file read/write steering, one-entry
// operand slot, busy-scoreboard stalls. Define OPFETCH_FORWARD_EN for wb bypass.
module operand_fetch_ctrl
  import opfetch_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DEPTH_LOG-1:0] in_src_a,
  input  logic [DEPTH_LOG-1:0] in_src_b,
  input  logic [DEPTH_LOG-1:0] in_dst,
  input  logic                 in_wr_en,
  output logic [DEPTH_LOG-1:0] rf_sel_a,
  output logic [DEPTH_LOG-1:0] rf_sel_b,
  input  logic [WIDTH-1:0]     rf_a,
  input  logic [WIDTH-1:0]     rf_b,
  output logic                 rf_rw,
  output logic [DEPTH_LOG-1:0] rf_dr,
  output logic [WIDTH-1:0]     rf_data,
  input  logic                 wb_valid,
  input  logic [DEPTH_LOG-1:0] wb_dst,
  input  logic [WIDTH-1:0]     wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [DEPTH_LOG-1:0] out_dst,
  output logic                 out_wr_en,
  output logic [DEPTH-1:0]     busy,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic                 busy_a;
  logic                 busy_b;
  logic                 busy_dst;
  logic                 hazard_a;
  logic                 hazard_b;
  logic                 hazard;
  logic                 slot_free;
  logic                 issue;
  logic [WIDTH-1:0]     opnd_a;
  logic [WIDTH-1:0]     opnd_b;

  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_a_reg;
  logic [WIDTH-1:0]     out_b_reg;
  logic [DEPTH_LOG-1:0] out_dst_reg;
  logic                 out_wr_en_reg;
  logic [CNT_W-1:0]     stall_cnt_reg;

  assign rf_sel_a = in_src_a;
  assign rf_sel_b = in_src_b;
  assign rf_rw    = wb_valid;
  assign rf_dr    = wb_dst;
  assign rf_data  = wb_data;

  opfetch_scoreboard #(
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (issue & in_wr_en),
    .set_idx  (in_dst),
    .clr_en   (wb_valid),
    .clr_idx  (wb_dst),
    .src_a    (in_src_a),
    .src_b    (in_src_b),
    .dst      (in_dst),
    .busy     (busy),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy_dst (busy_dst)
  );

`ifdef OPFETCH_FORWARD_EN
  logic fwd_a;
  logic fwd_b;

  // A source being written back this cycle takes the writeback data directly;
  // the destination WAW check still waits on the busy vector alone.
  assign fwd_a    = wb_valid && (wb_dst == in_src_a);
  assign fwd_b    = wb_valid && (wb_dst == in_src_b);
  assign hazard_a = busy_a & ~fwd_a;
  assign hazard_b = busy_b & ~fwd_b;
  assign opnd_a   = fwd_a ? wb_data : rf_a;
  assign opnd_b   = fwd_b ? wb_data : rf_b;
`else
  assign hazard_a = busy_a;
  assign hazard_b = busy_b;
  assign opnd_a   = rf_a;
  assign opnd_b   = rf_b;
`endif

  assign hazard    = hazard_a | hazard_b | (in_wr_en & busy_dst);
  assign slot_free = ~out_valid_reg | out_ready;
  assign in_ready  = ~hazard & slot_free;
  assign issue     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_dst_reg   <= '0;
      out_wr_en_reg <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (issue) begin
        out_valid_reg <= 1'b1;
        out_a_reg     <= opnd_a;
        out_b_reg     <= opnd_b;
        out_dst_reg   <= in_dst;
        out_wr_en_reg <= in_wr_en;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // Only hazard stalls are counted; backpressure stalls are not.
      if (in_valid && hazard && slot_free && stall_cnt_reg != {CNT_W{1'b1}})
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_a     = out_a_reg;
  assign out_b     = out_b_reg;
  assign out_dst   = out_dst_reg;
  assign out_wr_en = out_wr_en_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Scoreboard bench for operand_fetch_ctrl: a register file model, directed
// stimulus pushing expected slot contents, and a monitor popping on consume.
`timescale 1ns/1ps
module tb_operand_fetch_ctrl;
  import opfetch_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int DL    = 4;
  localparam int CNT_W = 16;
`ifdef OPFETCH_FORWARD_EN
  localparam int RAW_STALLS = 2;
`else
  localparam int RAW_STALLS = 3;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid, in_ready, in_wr_en;
  logic [DL-1:0]    in_src_a, in_src_b, in_dst;
  logic [DL-1:0]    rf_sel_a, rf_sel_b, rf_dr, wb_dst, out_dst;
  logic [WIDTH-1:0] rf_a, rf_b, rf_data, wb_data, out_a, out_b;
  logic             rf_rw, wb_valid, out_valid, out_ready, out_wr_en;
  logic [DEPTH-1:0] busy;
  logic [CNT_W-1:0] stall_cnt;
  logic             rf_init;

  always #5 clk = ~clk;

  operand_fetch_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst), .in_wr_en(in_wr_en),
    .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b), .rf_a(rf_a), .rf_b(rf_b),
    .rf_rw(rf_rw), .rf_dr(rf_dr), .rf_data(rf_data),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dst(out_dst), .out_wr_en(out_wr_en),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  // Register file model: combinational read, write on the clock edge
  logic [WIDTH-1:0] rf_mem [DEPTH];
  assign rf_a = rf_mem[rf_sel_a];
  assign rf_b = rf_mem[rf_sel_b];
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < DEPTH; i++) rf_mem[i] <= '0;
    end else if (rf_rw) begin
      rf_mem[rf_dr] <= rf_data;
    end
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [DL-1:0]    dst;
    logic             wr;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL slot_unexpected: got a=%h b=%h dst=%0d wr=%0b, required no output",
                 out_a, out_b, out_dst, out_wr_en);
      end else begin
        exp_e = exp_q.pop_front();
        if ({out_a, out_b, out_dst, out_wr_en} !== exp_e) begin
          errors++;
          $display("FAIL slot_data: got a=%h b=%h dst=%0d wr=%0b, required a=%h b=%h dst=%0d wr=%0b",
                   out_a, out_b, out_dst, out_wr_en, exp_e.a, exp_e.b, exp_e.dst, exp_e.wr);
        end else begin
          $display("txn a=%h b=%h dst=%0d wr=%0b ok", out_a, out_b, out_dst, out_wr_en);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic present(input instr_t ins);
    in_valid = 1'b1;
    in_src_a = ins.src_a;
    in_src_b = ins.src_b;
    in_dst   = ins.dst;
    in_wr_en = ins.wr_en;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_wr_en = 1'b0;
  endtask

  task automatic set_wb(input wb_t w);
    wb_valid = w.valid;
    wb_dst   = w.dst;
    wb_data  = w.data;
  endtask

  initial begin
    in_valid = 0; in_src_a = 0; in_src_b = 0; in_dst = 0; in_wr_en = 0;
    wb_valid = 0; wb_dst = 0; wb_data = 0; out_ready = 1; rf_init = 0;
    repeat (2) tick;
    rf_init = 1;
    at_neg;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset_out_a", out_a, 32'h0);
    rstn = 1'b1;
    tick;

    // Preload r1=5, r2=7 through the write pass-through
    set_wb(wb_t'{valid: 1'b1, dst: 4'd1, data: 32'd5}); tick;
    set_wb(wb_t'{valid: 1'b1, dst: 4'd2, data: 32'd7}); tick;
    set_wb(wb_t'('0));

    // Back-to-back independent issues
    present(instr_t'{src_a: 4'd1, src_b: 4'd2, dst: 4'd3, wr_en: 1'b1});
    at_neg; chk("b2b_ready0", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'd5, b: 32'd7, dst: 4'd3, wr: 1'b1});
    tick;
    present(instr_t'{src_a: 4'd2, src_b: 4'd1, dst: 4'd4, wr_en: 1'b1});
    at_neg; chk("b2b_ready1", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'd7, b: 32'd5, dst: 4'd4, wr: 1'b1});
    tick;
    idle;
    at_neg; chk("b2b_busy", 32'(busy), 32'h0018);
    tick; set_wb(wb_t'{valid: 1'b1, dst: 4'd3, data: 32'h33});
    tick; set_wb(wb_t'{valid: 1'b1, dst: 4'd4, data: 32'h44});
    tick; set_wb(wb_t'('0));
    at_neg; chk("wb_clear_busy", 32'(busy), 32'h0);

    // RAW stall on r3
    tick;
    present(instr_t'{src_a: 4'd0, src_b: 4'd0, dst: 4'd3, wr_en: 1'b1});
    at_neg; chk("raw_first_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'd0, b: 32'd0, dst: 4'd3, wr: 1'b1});
    tick;
    present(instr_t'{src_a: 4'd3, src_b: 4'd0, dst: 4'd5, wr_en: 1'b1});
    at_neg; chk("raw_stall_c1", 32'(in_ready), 32'h0);
    tick;
    at_neg; chk("raw_stall_c2", 32'(in_ready), 32'h0);
    tick;
    set_wb(wb_t'{valid: 1'b1, dst: 4'd3, data: 32'hAB});
`ifdef OPFETCH_FORWARD_EN
    at_neg; chk("raw_fwd_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'hAB, b: 32'd0, dst: 4'd5, wr: 1'b1});
    tick;
    set_wb(wb_t'('0)); idle;
`else
    at_neg; chk("raw_wb_cycle_ready", 32'(in_ready), 32'h0);
    tick;
    set_wb(wb_t'('0));
    at_neg; chk("raw_after_wb_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'hAB, b: 32'd0, dst: 4'd5, wr: 1'b1});
    tick;
    idle;
`endif
    at_neg;
    chk("raw_stall_cnt", 32'(stall_cnt), 32'(RAW_STALLS));
    chk("raw_busy", 32'(busy), 32'h0020);
    tick; set_wb(wb_t'{valid: 1'b1, dst: 4'd5, data: 32'h55});
    tick; set_wb(wb_t'('0));

    // Backpressure: slot holds, no hazard stall counted
    out_ready = 1'b0;
    present(instr_t'{src_a: 4'd1, src_b: 4'd2, dst: 4'd7, wr_en: 1'b0});
    at_neg; chk("bp_first_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'd5, b: 32'd7, dst: 4'd7, wr: 1'b0});
    tick;
    present(instr_t'{src_a: 4'd2, src_b: 4'd2, dst: 4'd8, wr_en: 1'b0});
    at_neg;
    chk("bp_ready", 32'(in_ready), 32'h0);
    tick;
    at_neg;
    chk("bp_hold_valid", 32'(out_valid), 32'h1);
    chk("bp_hold_a", out_a, 32'd5);
    chk("bp_hold_ready", 32'(in_ready), 32'h0);
    chk("bp_stall_cnt", 32'(stall_cnt), 32'(RAW_STALLS));
    tick;
    out_ready = 1'b1;
    at_neg; chk("bp_release_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'd7, b: 32'd7, dst: 4'd8, wr: 1'b0});
    tick;
    idle;

    // Set wins over a same-cycle writeback to a non-busy register
    present(instr_t'{src_a: 4'd0, src_b: 4'd0, dst: 4'd6, wr_en: 1'b1});
    set_wb(wb_t'{valid: 1'b1, dst: 4'd6, data: 32'h66});
    at_neg;
    chk("sw_rf_rw", 32'(rf_rw), 32'h1);
    chk("sw_rf_dr", 32'(rf_dr), 32'd6);
    chk("sw_rf_data", rf_data, 32'h66);
    chk("sw_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'd0, b: 32'd0, dst: 4'd6, wr: 1'b1});
    tick;
    idle; set_wb(wb_t'('0));
    at_neg; chk("sw_busy", 32'(busy), 32'h0040);
    tick; set_wb(wb_t'{valid: 1'b1, dst: 4'd6, data: 32'h67});
    tick; set_wb(wb_t'('0));

    // Reset mid-traffic with a held slot and a busy register
    out_ready = 1'b0;
    present(instr_t'{src_a: 4'd0, src_b: 4'd0, dst: 4'd9, wr_en: 1'b1});
    tick;
    idle;
    at_neg; chk("mid_busy_pre", 32'(busy), 32'h0200);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'h0);
    chk("mid_rst_dst", 32'(out_dst), 32'h0);
    exp_q.delete();
    tick;
    at_neg;
    rstn = 1'b1;
    tick;
    out_ready = 1'b1;
    present(instr_t'{src_a: 4'd1, src_b: 4'd2, dst: 4'd3, wr_en: 1'b1});
    at_neg; chk("post_rst_ready", 32'(in_ready), 32'h1);
    exp_q.push_back(exp_t'{a: 32'd5, b: 32'd7, dst: 4'd3, wr: 1'b1});
    tick;

    // Saturation: hold a RAW hazard on r3 for 2^CNT_W+5 cycles
    present(instr_t'{src_a: 4'd3, src_b: 4'd0, dst: 4'd10, wr_en: 1'b0});
    at_neg;
    chk("sat_start", 32'(stall_cnt), 32'h0);
    chk("sat_ready", 32'(in_ready), 32'h0);
    repeat ((1 << CNT_W) + 5) tick;
    at_neg; chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    tick;
    idle;
    tick;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
- Initiator-side controller for the register file. It accepts decoded instructions over a valid/ready handshake and drives the register file read selects.
- It captures both operands into a registered output slot and forwards execute-stage writebacks to the register file write port.
- A per-register busy scoreboard stalls issue on RAW/WAW hazards.
- Sits between decode and execute in the datapath.

Parameters:
- WIDTH, 32, data width of a register.
- DEPTH, 16, number of architectural registers.
- DEPTH_LOG, $clog2(DEPTH), register index width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous reset, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle.
- in_src_a  in  DEPTH_LOG  source A index.
- in_src_b  in  DEPTH_LOG  source B index.
- in_dst  in  DEPTH_LOG  destination index.
- in_wr_en  in  1  instruction will write in_dst.
- rf_sel_a  out  DEPTH_LOG  register file read select A.
- rf_sel_b  out  DEPTH_LOG  register file read select B.
- rf_a  in  WIDTH  register file read data A (combinational).
- rf_b  in  WIDTH  register file read data B (combinational).
- rf_rw  out  1  register file write enable.
- rf_dr  out  DEPTH_LOG  register file write index.
- rf_data  out  WIDTH  register file write data.
- wb_valid  in  1  execute writeback strobe.
- wb_dst  in  DEPTH_LOG  writeback index.
- wb_data  in  WIDTH  writeback data.
- out_valid  out  1  operand slot full.
- out_ready  in  1  execute consumes slot.
- out_a  out  WIDTH  captured operand A.
- out_b  out  WIDTH  captured operand B.
- out_dst  out  DEPTH_LOG  destination index of slot.
- out_wr_en  out  1  write flag of slot.
- busy  out  DEPTH  scoreboard vector.
- stall_cnt  out  CNT_W  hazard stall cycles, saturating.

Behaviour:
- Reset (async, rstn low): out_valid=0; out_a, out_b, out_dst, out_wr_en all 0; busy all 0; stall_cnt=0. Reset mid-operation drops the slot contents and all pending busy bits.
- Read selects: rf_sel_a=in_src_a and rf_sel_b=in_src_b, combinational, always driven.
- Write pass-through: rf_rw=wb_valid, rf_dr=wb_dst, rf_data=wb_data, combinational. The register file commits at the same clk edge.
- Hazard: (busy[in_src_a] | busy[in_src_b] | (in_wr_en & busy[in_dst])).
  - Evaluated on the current busy vector.
  - A same-cycle writeback does NOT clear the hazard (without the optional feature).
- Slot free: !out_valid | out_ready.
- in_ready = !hazard & slot_free. Issue = in_valid & in_ready.
- On issue:
  - Next edge: out_a<=rf_a, out_b<=rf_b, out_dst<=in_dst, out_wr_en<=in_wr_en, out_valid<=1.
  - Latency is 1 cycle from acceptance to out_valid.
  - If in_wr_en, busy[in_dst]<=1.
- Slot drain: out_valid & out_ready with no issue -> out_valid<=0. Issue and drain in the same cycle keep out_valid=1 with the new contents (full throughput, one instruction per cycle).
- Hold: out_valid & !out_ready -> slot contents hold, in_ready=0.
- Writeback: wb_valid clears busy[wb_dst] at the edge.
  - If the same edge issues an instruction with in_wr_en and in_dst==wb_dst, the set wins and busy stays 1.
  - Writeback to a non-busy register is legal: data is written and busy is unchanged.
- Earliest read after writeback: a source waiting on writeback becomes issuable the cycle after wb_valid. The register file then returns the new value.
- stall_cnt: increments each cycle in which in_valid & hazard & slot_free. Saturates at all-ones.
- All index arithmetic is unsigned DEPTH_LOG bits. No reserved zero register; index 0 is an ordinary register.

Optional Feature:
- Macro: OPFETCH_FORWARD_EN.
- Defined: a source whose busy bit is set but which matches wb_dst while wb_valid=1 is not a hazard.
  - The operand is captured from wb_data instead of rf_a/rf_b.
  - WAW check on in_dst still uses the busy vector, so a dst equal to wb_dst issues, and busy is re-set per the set-wins rule.
- Undefined: no bypass mux. The instruction stalls exactly one extra cycle and reads the register file.

Decomposition:
- Shared package (opfetch_pkg):
  - Default WIDTH/DEPTH constants.
  - The instruction bundle typedef {src_a, src_b, dst, wr_en}.
  - The writeback bundle typedef {valid, dst, data}.
- One natural sub-module: opfetch_scoreboard, holding the busy vector with set/clear ports, set-wins priority, and the hazard-check outputs.

Test Plan:
- Reset: assert rstn=0 mid-traffic -> busy=0, out_valid=0, stall_cnt=0 immediately; first issue after release is accepted with in_ready=1.
- Back-to-back independent issues:
  - Stimulus: r1=5, r2=7 preloaded; issue src_a=1, src_b=2, dst=3, then src_a=2, src_b=1, dst=4, with out_ready=1.
  - Response: out_a/out_b = 5/7 then 7/5 on consecutive cycles; busy[3], busy[4] set.
- RAW stall:
  - Stimulus: issue dst=3, then src_a=3; wb_valid with wb_dst=3, wb_data=0xAB two cycles later.
  - Response without the feature: in_ready=0 until the cycle after wb, then out_a=0xAB; stall_cnt=3.
  - Response with OPFETCH_FORWARD_EN: issue in the wb cycle with out_a=0xAB; stall_cnt=2.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, slot holds, stall_cnt unchanged; releasing out_ready drains and accepts the next instruction in the same cycle.
- Set-wins: wb_valid with wb_dst=6 in the same cycle as an issue with dst=6 and wr_en=1 (r6 not busy before) -> busy[6]=1 after the edge; rf_rw=1 with rf_dr=6 that cycle.
- Saturation: force a hazard for 2^CNT_W+5 cycles -> stall_cnt holds at 0xFFFF.
